pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline stage register that supersedes the fixed-field inter-stage latches in the 5-stage core. It carries one opaque data word and one control word per beat, and adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, so hazard logic can stall or squash any stage without rewriting the latch.

---
 rtl/pipe_stage_elastic_if.sv | 47 ++++
 rtl/pipe_stage_elastic.sv | 135 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for pipe_stage_elastic: upstream and downstream
// valid/ready channels plus flush and status.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic              flush_i;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        output in_ctrl_i,
        output out_ready_i,
        output flush_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_ctrl_o,
        input  occupancy_o,
        input  stall_cnt_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  in_ctrl_i,
        input  out_ready_i,
        input  flush_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_ctrl_o,
        output occupancy_o,
        output stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: main + skid entry, flush, bubble masking.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_elastic #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    pipe_stage_elastic_if.slave bus
);

    // Encoding doubles as occupancy; bit 1 is the skid-valid flag.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              main_vld;
    logic              skid_vld;
    logic              in_rdy;
    logic              in_fire;
    logic              out_fire;
    logic              ld_main_in;
    logic              ld_main_skid;
    logic              ld_skid;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    assign main_vld = (state_q != EMPTY);
    assign skid_vld = state_q[1];
    assign in_rdy   = ~skid_vld & rst_i;
    assign in_fire  = bus.in_valid_i & in_rdy;
    assign out_fire = main_vld & bus.out_ready_i;

    // Next state and register load selects; flush overrides handshakes.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = HALF;
                    ld_main_in = 1'b1;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d      = HALF;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush_i) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main entry: loads from input or promotes the skid entry.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (ld_main_in) begin
            main_data_q <= bus.in_data_i;
            main_ctrl_q <= bus.in_ctrl_i;
        end else if (ld_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
        end
    end

    // Skid entry: catches the beat accepted while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (ld_skid) begin
            skid_data_q <= bus.in_data_i;
            skid_ctrl_q <= bus.in_ctrl_i;
        end
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.out_valid_o = main_vld;
    assign bus.out_data_o  = main_data_q;
    assign bus.out_ctrl_o  = main_vld ? main_ctrl_q : '0;
    assign bus.occupancy_o = state_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles the output is held by backpressure.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_q <= '0;
        end else if (main_vld && !bus.out_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt_o = stall_q;
`else
    assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: directed scenarios then
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_elastic;

    localparam int DW = 128;
    localparam int CW = 8;
    localparam int NW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    beat_t         sb[$];
    beat_t         nb;
    logic [DW-1:0] last_d = '0;
    int            cnt_m = 0;
    int            checks = 0;
    int            fails = 0;
    bit            mon_en = 1'b0;
    bit            m_in;
    bit            m_out;

    task automatic chk(input string n, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef PIPE_STAGE_STALL_CNT_EN
        return cnt_m;
`else
        return 0;
`endif
    endfunction

    // Reference model: a FIFO of at most two accepted beats.
    always @(posedge clk) begin
        m_in  = bus.in_valid_i && (sb.size() < 2) && rst;
        m_out = (sb.size() > 0) && bus.out_ready_i;
        if (!rst) begin
            sb.delete();
            last_d = '0;
            cnt_m  = 0;
        end else begin
            if ((sb.size() > 0) && !bus.out_ready_i && (cnt_m < (1 << NW) - 1))
                cnt_m++;
            if (bus.flush_i) begin
                sb.delete();
            end else begin
                if (m_out) void'(sb.pop_front());
                if (m_in) begin
                    nb.d = bus.in_data_i;
                    nb.c = bus.in_ctrl_i;
                    sb.push_back(nb);
                end
                if (sb.size() > 0) last_d = sb[0].d;
            end
        end
        mon_en <= 1'b1;
    end

    // Monitor: compare presented outputs with the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", DW'(bus.out_valid_o), DW'(sb.size() > 0));
            chk("in_ready", DW'(bus.in_ready_o), DW'((sb.size() < 2) && rst));
            chk("occupancy", DW'(bus.occupancy_o), DW'(sb.size()));
            chk("out_data_hold", bus.out_data_o, last_d);
            if (sb.size() > 0) begin
                chk("out_data", bus.out_data_o, sb[0].d);
                chk("out_ctrl", DW'(bus.out_ctrl_o), DW'(sb[0].c));
            end else begin
                chk("bubble_ctrl", DW'(bus.out_ctrl_o), '0);
            end
            chk("stall_cnt", DW'(bus.stall_cnt_o), DW'(exp_cnt()));
        end
    end

    task automatic drv(input bit v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input bit r, input bit f);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.in_ctrl_i   = c;
        bus.out_ready_i = r;
        bus.flush_i     = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_d();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] dval;

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.in_ctrl_i   = '0;
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(bus.out_valid_o), '0);
        chk("rst_data", bus.out_data_o, '0);
        chk("rst_ready", DW'(bus.in_ready_o), '0);
        rst = 1'b1;
        #1;
        chk("rel_ready", DW'(bus.in_ready_o), DW'(1));

        // stream 0..7 at full rate
        for (int i = 0; i < 8; i++) drv(1, DW'(i), CW'($urandom), 1, 0);
        chk("stream_last", bus.out_data_o, DW'(7));
        repeat (2) drv(0, '0, '0, 1, 0);

        // backpressure A, B, C
        drv(1, DW'(32'hA), 8'h11, 1, 0);
        drv(1, DW'(32'hB), 8'h22, 0, 0);
        chk("bp_ready_low", DW'(bus.in_ready_o), '0);
        drv(1, DW'(32'hC), 8'h33, 0, 0);
        drv(1, DW'(32'hC), 8'h33, 1, 0);
        drv(1, DW'(32'hC), 8'h33, 1, 0);
        repeat (3) drv(0, '0, '0, 1, 0);

        // flush while full, D discarded
        drv(1, DW'(32'hE), 8'h44, 0, 0);
        drv(1, DW'(32'hF), 8'h55, 0, 0);
        chk("pre_flush_occ", DW'(bus.occupancy_o), DW'(2));
        drv(1, DW'(32'hD), 8'h66, 0, 1);
        chk("flush_valid", DW'(bus.out_valid_o), '0);
        chk("flush_ctrl", DW'(bus.out_ctrl_o), '0);
        chk("flush_occ", DW'(bus.occupancy_o), '0);
        repeat (3) drv(0, '0, '0, 1, 0);

        // bubble masking
        drv(1, DW'(32'h99), 8'hFF, 1, 0);
        chk("bubble_ff", DW'(bus.out_ctrl_o), DW'(8'hFF));
        drv(0, '0, '0, 1, 0);
        chk("bubble_00", DW'(bus.out_ctrl_o), '0);

        // reset while full
        drv(1, rnd_d(), 8'h0F, 0, 0);
        drv(1, rnd_d(), 8'hF0, 0, 0);
        rst = 1'b0;
        drv(1, rnd_d(), 8'h3C, 0, 0);
        chk("mrst_valid", DW'(bus.out_valid_o), '0);
        chk("mrst_data", bus.out_data_o, '0);
        chk("mrst_occ", DW'(bus.occupancy_o), '0);
        chk("mrst_ready", DW'(bus.in_ready_o), '0);
        rst = 1'b1;
        #1;
        chk("mrst_rel", DW'(bus.in_ready_o), DW'(1));

        // stall counter saturation
        drv(1, DW'(32'h5), 8'h01, 0, 0);
        repeat (20) drv(0, '0, '0, 0, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall_sat", DW'(bus.stall_cnt_o), DW'(15));
`else
        chk("stall_off", DW'(bus.stall_cnt_o), '0);
`endif
        drv(0, '0, '0, 1, 1);
        chk("stall_flush", DW'(bus.stall_cnt_o), DW'(exp_cnt()));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) rst = 1'b0;
            else rst = 1'b1;
            dval = rnd_d();
            drv($urandom_range(3) != 0, dval, CW'($urandom),
                $urandom_range(2) != 0, $urandom_range(39) == 0);
        end
        rst = 1'b1;
        repeat (4) drv(0, '0, '0, 1, 0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
